// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pipe
//  Purpose  : Parametrised pipelined binary decoder (one-hot, thermometer,
//             inverted one-hot) with valid/ready handshakes on both sides,
//             out-of-range error flagging and a saturating error counter.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_pipe #(
  parameter int IN_W   = 5,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_a,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_z,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [1:0]  c_MODE_ONEHOT = 2'b00;
  localparam logic [1:0]  c_MODE_THERM  = 2'b01;
  localparam logic [1:0]  c_MODE_RSVD   = 2'b11;
  localparam logic [31:0] c_OUT_W       = 32'(OUT_W);

  // Per-stage {valid, z, err}; index STAGES-1 is the output stage
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_err;
  logic [OUT_W-1:0]  r_z [STAGES];
  logic [CNT_W-1:0]  r_err_count;

  // w_ready[k] means stage k may load this cycle; w_ready[STAGES] is the consumer
  logic [STAGES:0]   w_ready;
  logic [OUT_W-1:0]  w_dec_z;
  logic              w_dec_err;
  logic [31:0]       w_code;

  // Widen the code so it can be compared against OUT_W even when OUT_W == 2^IN_W
  assign w_code = 32'(in_a);

  // Decode the incoming code; reserved mode or out-of-range code yields z = 0 with err
  always_comb begin
    w_dec_z   = '0;
    w_dec_err = 1'b0;
    if (in_mode == c_MODE_RSVD || w_code >= c_OUT_W) begin
      w_dec_err = 1'b1;
    end else begin
      for (int i = 0; i < OUT_W; i++) begin
        case (in_mode)
          c_MODE_ONEHOT: w_dec_z[i] = (32'(i) == w_code);
          c_MODE_THERM:  w_dec_z[i] = (32'(i) <= w_code);
          default:       w_dec_z[i] = (32'(i) != w_code);
        endcase
      end
    end
  end

  // Ready ripples back from the consumer: a stage can load if empty or its successor drains
  always_comb begin
    w_ready          = '0;
    w_ready[STAGES]  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_valid[k] || w_ready[k+1];
    end
  end

  assign in_ready = w_ready[0];

  // Stage registers: stage 0 captures the decode, later stages copy their predecessor.
  // Payload only updates when a valid entry arrives so bubbles keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_z[k] <= '0;
      end
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_z[0]   <= w_dec_z;
          r_err[0] <= w_dec_err;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_z[k]   <= r_z[k-1];
            r_err[k] <= r_err[k-1];
          end
        end
      end
    end
  end

  // Count error results actually handed to the consumer, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (out_valid && out_ready && out_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_z     = r_z[STAGES-1];
  assign out_err   = r_err[STAGES-1];
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_pipe
//  Purpose  : Self-checking bench for decoder_pipe. Instance u_d uses the
//             default parameters; instance u_s uses STAGES=2, OUT_W=24,
//             CNT_W=4 for backpressure, out-of-range and saturation cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_pipe;

  typedef struct {
    logic [31:0] z;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [1:0]  m;
    logic [31:0] z;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv_d = 1'b0, in_ready_d, out_valid_d, out_ready_d = 1'b0, out_err_d;
  logic [4:0]  a_d = '0;
  logic [1:0]  m_d = '0;
  logic [31:0] out_z_d;
  logic [15:0] err_count_d;

  logic        iv_s = 1'b0, in_ready_s, out_valid_s, out_ready_s = 1'b0, out_err_s;
  logic [4:0]  a_s = '0;
  logic [1:0]  m_s = '0;
  logic [23:0] out_z_s;
  logic [3:0]  err_count_s;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   cnt_d = 0, cnt_s = 0;
  int   deliv_d = 0, deliv_s = 0;
  bit   lat_d = 1'b0;
  exp_t q_d[$];
  exp_t q_s[$];
  exp_t e_d, e_s;
  vec_t vecs[8];

  decoder_pipe u_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_d), .in_ready(in_ready_d), .in_a(a_d), .in_mode(m_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d),
    .out_z(out_z_d), .out_err(out_err_d), .err_count(err_count_d)
  );

  decoder_pipe #(.IN_W(5), .OUT_W(24), .STAGES(2), .CNT_W(4)) u_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_s), .in_ready(in_ready_s), .in_a(a_s), .in_mode(m_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_z(out_z_s), .out_err(out_err_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode from the rules: plain shifts and masks on 64-bit integers
  function automatic exp_t model(input int ow, input logic [4:0] a, input logic [1:0] m, input int c);
    exp_t e;
    longint unsigned one, full;
    e.cyc = c;
    e.err = 1'b0;
    e.z   = '0;
    if (m == 2'd3 || int'(a) >= ow) begin
      e.err = 1'b1;
    end else begin
      one  = 64'd1 << a;
      full = (64'd1 << ow) - 64'd1;
      case (m)
        2'd0:    e.z = 32'(one);
        2'd1:    e.z = 32'((one << 1) - 64'd1);
        default: e.z = 32'(~one & full);
      endcase
    end
    return e;
  endfunction

  // Reset discards everything in flight
  always @(negedge rst_n) begin
    q_d.delete();
    q_s.delete();
    cnt_d = 0;
    cnt_s = 0;
  end

  // Scoreboard for u_d: handshakes observed mid-cycle take effect at the next edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("err_count_d", 64'(err_count_d), 64'(cnt_d));
      if (out_valid_d && out_ready_d) begin
        if (q_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_d: unexpected output z=%0h got, none required", out_z_d);
        end else begin
          e_d = q_d.pop_front();
          chk("z_d", 64'(out_z_d), 64'(e_d.z));
          chk("err_d", 64'(out_err_d), 64'(e_d.err));
          if (lat_d) chk("lat_d", 64'(cyc - e_d.cyc), 64'd1);
          if (e_d.err && cnt_d != 65535) cnt_d++;
          deliv_d++;
        end
      end
      if (iv_d && in_ready_d) q_d.push_back(model(32, a_d, m_d, cyc));
    end
  end

  // Scoreboard for u_s
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("err_count_s", 64'(err_count_s), 64'(cnt_s));
      if (out_valid_s && out_ready_s) begin
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_s: unexpected output z=%0h got, none required", out_z_s);
        end else begin
          e_s = q_s.pop_front();
          chk("z_s", 64'(out_z_s), 64'(e_s.z));
          chk("err_s", 64'(out_err_s), 64'(e_s.err));
          chk("lat_s_min", 64'(cyc - e_s.cyc >= 2), 64'd1);
          if (e_s.err && cnt_s != 15) cnt_s++;
          deliv_s++;
        end
      end
      if (iv_s && in_ready_s) q_s.push_back(model(24, a_s, m_s, cyc));
    end
  end

  task automatic send_s(input logic [4:0] a, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    iv_s = 1'b1; a_s = a; m_s = m;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready_s) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_s: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    iv_s = 1'b0;
  endtask

  task automatic wait_out_s();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (out_valid_s) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_out_s: out_valid stayed 0, required 1");
    end
  endtask

  initial begin
    int d0;
    vecs[0] = '{5'd4,  2'd1, 32'h0000001F, 1'b0};
    vecs[1] = '{5'd4,  2'd2, 32'hFFFFFFEF, 1'b0};
    vecs[2] = '{5'd4,  2'd3, 32'h00000000, 1'b1};
    vecs[3] = '{5'd31, 2'd1, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{5'd0,  2'd0, 32'h00000001, 1'b0};
    vecs[5] = '{5'd31, 2'd0, 32'h80000000, 1'b0};
    vecs[6] = '{5'd31, 2'd2, 32'h7FFFFFFF, 1'b0};
    vecs[7] = '{5'd0,  2'd1, 32'h00000001, 1'b0};

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_d", 64'(out_valid_d), 64'd0);
    chk("rst_z_d", 64'(out_z_d), 64'd0);
    chk("rst_err_d", 64'(out_err_d), 64'd0);
    chk("rst_cnt_d", 64'(err_count_d), 64'd0);
    chk("rst_valid_s", 64'(out_valid_s), 64'd0);
    chk("rst_cnt_s", 64'(err_count_s), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rdy_after_rst_d", 64'(in_ready_d), 64'd1);
    chk("rdy_after_rst_s", 64'(in_ready_s), 64'd1);

    // ---- sweep one-hot, back-to-back, latency checked
    out_ready_d = 1'b1;
    lat_d = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      iv_d = 1'b1; a_d = 5'(i); m_d = 2'd0;
    end
    @(posedge clk); #1;
    iv_d = 1'b0;
    repeat (3) @(negedge clk);
    lat_d = 1'b0;
    chk("sweep_count", 64'(deliv_d), 64'd32);
    chk("sweep_errcnt", 64'(err_count_d), 64'd0);

    // ---- table of mode vectors
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      iv_d = 1'b1; a_d = vecs[v].a; m_d = vecs[v].m;
      @(posedge clk); #1;
      iv_d = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", v), 64'(out_valid_d), 64'd1);
      chk($sformatf("tbl%0d_z", v), 64'(out_z_d), 64'(vecs[v].z));
      chk($sformatf("tbl%0d_err", v), 64'(out_err_d), 64'(vecs[v].err));
    end
    @(negedge clk);
    chk("tbl_errcnt", 64'(err_count_d), 64'd1);

    // ---- randomized traffic on u_d
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      iv_d        = ($urandom_range(0, 3) != 0);
      a_d         = 5'($urandom_range(0, 31));
      m_d         = 2'($urandom_range(0, 3));
      out_ready_d = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv_d = 1'b0; out_ready_d = 1'b1;
    repeat (5) @(negedge clk);
    chk("rand_d_drained", 64'(q_d.size()), 64'd0);

    // ---- backpressure on the 2-stage instance
    out_ready_s = 1'b0;
    d0 = deliv_s;
    @(posedge clk); #1;
    iv_s = 1'b1; a_s = 5'd3; m_s = 2'd0;
    @(posedge clk); #1;
    a_s = 5'd7;
    @(posedge clk); #1;
    a_s = 5'd9;
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready_s), 64'd0);
    chk("bp_valid", 64'(out_valid_s), 64'd1);
    chk("bp_z", 64'(out_z_s), 64'h8);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_z", 64'(out_z_s), 64'h8);
      chk("bp_hold_rdy", 64'(in_ready_s), 64'd0);
    end
    @(posedge clk); #1;
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    iv_s = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_delivered", 64'(deliv_s - d0), 64'd3);
    chk("bp_drained", 64'(out_valid_s), 64'd0);

    // ---- out-of-range on OUT_W=24
    send_s(5'd25, 2'd0);
    wait_out_s();
    chk("oor25_z", 64'(out_z_s), 64'd0);
    chk("oor25_err", 64'(out_err_s), 64'd1);
    send_s(5'd23, 2'd0);
    wait_out_s();
    chk("oor23_z", 64'(out_z_s), 64'h800000);
    chk("oor23_err", 64'(out_err_s), 64'd0);

    // ---- randomized traffic on u_s
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      iv_s        = ($urandom_range(0, 2) != 0);
      a_s         = 5'($urandom_range(0, 31));
      m_s         = 2'($urandom_range(0, 3));
      out_ready_s = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    iv_s = 1'b0; out_ready_s = 1'b1;
    repeat (5) @(negedge clk);
    chk("rand_s_drained", 64'(q_s.size()), 64'd0);

    // ---- saturation of the 4-bit counter
    for (int i = 0; i < 17; i++) send_s(5'(i), 2'd3);
    repeat (4) @(negedge clk);
    chk("sat_15", 64'(err_count_s), 64'd15);
    send_s(5'd30, 2'd0);
    send_s(5'd1, 2'd3);
    repeat (4) @(negedge clk);
    chk("sat_stays", 64'(err_count_s), 64'd15);

    // ---- asynchronous reset with two entries in flight
    out_ready_s = 1'b0;
    @(posedge clk); #1;
    iv_s = 1'b1; a_s = 5'd1; m_s = 2'd3;
    @(posedge clk); #1;
    a_s = 5'd2; m_s = 2'd0;
    @(posedge clk); #1;
    iv_s = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid_s), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_s), 64'd0);
    chk("mid_rst_z", 64'(out_z_s), 64'd0);
    chk("mid_rst_err", 64'(out_err_s), 64'd0);
    chk("mid_rst_cnt", 64'(err_count_s), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready_s), 64'd1);
    out_ready_s = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid_s), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
